// File: rtl/key_debouncer_if.sv
// Key debouncer signal bundle: raw key levels in, debounced levels/events out.
interface key_debouncer_if;
  logic [3:0] i_key_raw;
  logic [3:0] o_key;
  logic [3:0] o_press;
  logic [3:0] o_release;
  logic       o_any;
  logic [1:0] o_code;

  // Stimulus/consumer side: drives the raw keys, observes debounced results.
  modport master (
    output i_key_raw,
    input  o_key, o_press, o_release, o_any, o_code
  );

  // Debouncer side.
  modport slave (
    input  i_key_raw,
    output o_key, o_press, o_release, o_any, o_code
  );
endinterface

// File: rtl/key_debouncer.sv
// Four-key push-button debouncer: two-flop synchronizer and a per-key
// four-state FSM that accepts a level change only after DEBOUNCE_CYCLES
// consecutive identical synchronized samples. Emits registered levels,
// press/release pulses, an any-pressed flag and the lowest pressed index.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic           i_clk,
  input  logic           i_reset,
  key_debouncer_if.slave bus
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] RELEASED     = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  logic [3:0]    sync1, sync2;
  logic [1:0]    state    [4];
  logic [1:0]    state_nx [4];
  logic [CW-1:0] cnt      [4];
  logic [CW-1:0] cnt_nx   [4];
  logic [3:0]    key_q, press_q, release_q;
  logic          any_q;
  logic [1:0]    code_q;
  logic [3:0]    key_nx, press_nx, release_nx;
  logic [1:0]    code_nx;

  // Two-flop synchronizer for every raw key bit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.i_key_raw;
      sync2 <= sync1;
    end
  end

  // Per-key debounce FSM next-state, counter and event decode.
  always_comb begin
    key_nx     = key_q;
    press_nx   = '0;
    release_nx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      state_nx[i] = state[i];
      cnt_nx[i]   = cnt[i];
      case (state[i])
        RELEASED: begin
          if (sync2[i]) begin
            state_nx[i] = PRESS_WAIT;
            cnt_nx[i]   = CNT_ONE;
          end else begin
            cnt_nx[i] = '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync2[i]) begin
            state_nx[i] = RELEASED;
            cnt_nx[i]   = '0;
          end else if (cnt[i] == CNT_LAST) begin
            state_nx[i] = PRESSED;
            cnt_nx[i]   = '0;
            key_nx[i]   = 1'b1;
            press_nx[i] = 1'b1;
          end else begin
            cnt_nx[i] = cnt[i] + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!sync2[i]) begin
            state_nx[i] = RELEASE_WAIT;
            cnt_nx[i]   = CNT_ONE;
          end else begin
            cnt_nx[i] = '0;
          end
        end
        default: begin
          if (sync2[i]) begin
            state_nx[i] = PRESSED;
            cnt_nx[i]   = '0;
          end else if (cnt[i] == CNT_LAST) begin
            state_nx[i]   = RELEASED;
            cnt_nx[i]     = '0;
            key_nx[i]     = 1'b0;
            release_nx[i] = 1'b1;
          end else begin
            cnt_nx[i] = cnt[i] + CNT_ONE;
          end
        end
      endcase
    end
  end

  // Lowest-numbered pressed key wins, taken from next-state levels.
  always_comb begin
    code_nx = 2'd0;
    if (key_nx[0])      code_nx = 2'd0;
    else if (key_nx[1]) code_nx = 2'd1;
    else if (key_nx[2]) code_nx = 2'd2;
    else if (key_nx[3]) code_nx = 2'd3;
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        state[i] <= RELEASED;
        cnt[i]   <= '0;
      end
      key_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
      any_q     <= 1'b0;
      code_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        state[i] <= state_nx[i];
        cnt[i]   <= cnt_nx[i];
      end
      key_q     <= key_nx;
      press_q   <= press_nx;
      release_q <= release_nx;
      any_q     <= |key_nx;
      code_q    <= code_nx;
    end
  end

  assign bus.o_key     = key_q;
  assign bus.o_press   = press_q;
  assign bus.o_release = release_q;
  assign bus.o_any     = any_q;
  assign bus.o_code    = code_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with DEBOUNCE_CYCLES=4 (6-edge latency).
module tb_key_debouncer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  key_debouncer_if bus ();

  key_debouncer #(.DEBOUNCE_CYCLES(4)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] key, input logic [3:0] prs,
                           input logic [3:0] rel, input logic any, input logic [1:0] code);
    check({tag, ".key"},     32'(bus.o_key),     32'(key));
    check({tag, ".press"},   32'(bus.o_press),   32'(prs));
    check({tag, ".release"}, 32'(bus.o_release), 32'(rel));
    check({tag, ".any"},     32'(bus.o_any),     32'(any));
    check({tag, ".code"},    32'(bus.o_code),    32'(code));
  endtask

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.i_key_raw = 4'b0000;
    tick();
    tick();
    check_all("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    rst = 1'b0;

    // Clean press of key1.
    bus.i_key_raw = 4'b0001;
    for (int i = 0; i < 5; i++) tick();
    check_all("press_e5", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    tick();
    check_all("press_e6", 4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd0);
    tick();
    check_all("press_e7", 4'b0001, 4'b0000, 4'b0000, 1'b1, 2'd0);

    // Release of key1.
    bus.i_key_raw = 4'b0000;
    for (int i = 0; i < 5; i++) tick();
    check_all("rel_e5", 4'b0001, 4'b0000, 4'b0000, 1'b1, 2'd0);
    tick();
    check_all("rel_e6", 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0);
    tick();
    check_all("rel_e7", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);

    // Glitch on key2: three high samples are one short of acceptance.
    bus.i_key_raw = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("glitch_hi", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    end
    bus.i_key_raw = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_all("glitch_lo", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    end

    // Bounce 1,0,1,0 on key3, then settle high.
    for (int i = 0; i < 4; i++) begin
      bus.i_key_raw = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      tick();
      check_all("bounce", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    end
    bus.i_key_raw = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all("settle_wait", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    end
    tick();
    check_all("settle_e6", 4'b0100, 4'b0100, 4'b0000, 1'b1, 2'd2);
    tick();
    check_all("settle_e7", 4'b0100, 4'b0000, 4'b0000, 1'b1, 2'd2);
    bus.i_key_raw = 4'b0000;
    for (int i = 0; i < 6; i++) tick();
    check_all("k3_rel", 4'b0000, 4'b0000, 4'b0100, 1'b0, 2'd0);
    tick();

    // Key4 and key2 together, then key2 released.
    bus.i_key_raw = 4'b1010;
    for (int i = 0; i < 6; i++) tick();
    check_all("dual_press", 4'b1010, 4'b1010, 4'b0000, 1'b1, 2'd1);
    tick();
    check_all("dual_hold", 4'b1010, 4'b0000, 4'b0000, 1'b1, 2'd1);
    bus.i_key_raw = 4'b1000;
    for (int i = 0; i < 5; i++) tick();
    check_all("k2_rel_e5", 4'b1010, 4'b0000, 4'b0000, 1'b1, 2'd1);
    tick();
    check_all("k2_rel_e6", 4'b1000, 4'b0000, 4'b0010, 1'b1, 2'd3);
    bus.i_key_raw = 4'b0000;
    for (int i = 0; i < 6; i++) tick();
    check_all("k4_rel", 4'b0000, 4'b0000, 4'b1000, 1'b0, 2'd0);
    tick();

    // Reset while key1 is pressed and still held.
    bus.i_key_raw = 4'b0001;
    for (int i = 0; i < 6; i++) tick();
    check_all("pre_rst", 4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_all("mid_rst", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all("post_rst_wait", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    end
    tick();
    check_all("post_rst_e6", 4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/key_debouncer.md
KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, the number of consecutive identical synchronized samples needed to accept a key change (10 ms at 50 MHz); legal range 2..2^24.
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port i_key_raw, input, 4 bits: asynchronous, bouncing push-button levels; bit n is key n+1, 1 = pressed.
REQ-005 The block SHALL have port o_key, output, 4 bits: registered debounced levels; bits 0..3 drive the tone selector's k1..k4.
REQ-006 The block SHALL have port o_press, output, 4 bits: registered one-cycle pulse per key on an accepted press.
REQ-007 The block SHALL have port o_release, output, 4 bits: registered one-cycle pulse per key on an accepted release.
REQ-008 The block SHALL have port o_any, output, 1 bit: registered; high when any o_key bit is high.
REQ-009 The block SHALL have port o_code, output, 2 bits: registered index of the lowest-numbered pressed key (key1 = 0 ... key4 = 3); 0 when none is pressed.

Function
REQ-010 Each i_key_raw bit SHALL pass through its own two-flop synchronizer (sync1, sync2) before any other logic uses it.
REQ-011 Each key SHALL have an independent FSM with states RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus a counter of width clog2(DEBOUNCE_CYCLES).
REQ-012 In RELEASED, sync2=1 SHALL move the FSM to PRESS_WAIT with cnt=1; otherwise it stays in RELEASED with cnt=0.
REQ-013 In PRESS_WAIT with sync2=1 and cnt=DEBOUNCE_CYCLES-1, the FSM SHALL go to PRESSED, set o_key[n]=1 and pulse o_press[n] for exactly one cycle, coincident with the o_key rise.
REQ-014 In PRESS_WAIT with sync2=1 and cnt<DEBOUNCE_CYCLES-1, cnt SHALL increment by 1.
REQ-015 In PRESS_WAIT with sync2=0, the FSM SHALL return to RELEASED with cnt=0 and generate no pulse.
REQ-016 PRESSED, RELEASE_WAIT and o_release SHALL mirror REQ-012 to REQ-015 with sync2 inverted; o_key[n] clears and o_release[n] pulses on the same edge.
REQ-017 Press latency SHALL be exactly DEBOUNCE_CYCLES+2 rising edges, counted from the first edge that samples i_key_raw[n]=1, with the input held stable throughout; release latency SHALL be identical.
REQ-018 Any bounce shorter than DEBOUNCE_CYCLES synchronized samples SHALL leave o_key unchanged and produce no pulse.
REQ-019 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-020 Keys SHALL be fully independent: simultaneous presses or releases on several keys SHALL produce simultaneous pulses on every affected bit.
REQ-021 o_any and o_code SHALL be registered from the next-state value of o_key, so they change on the same edge as o_key.
REQ-022 When several keys are pressed, o_code SHALL report the lowest index, matching the downstream k1-first priority.
REQ-023 o_press[n] and o_release[n] SHALL never both be high on the same cycle.

Reset
REQ-024 While i_reset=1 at a rising edge, every FSM SHALL go to RELEASED, and all counters, synchronizer flops and outputs (o_key, o_press, o_release, o_any, o_code) SHALL go to 0.
REQ-025 A reset asserted mid-operation (in PRESSED or either WAIT state) SHALL NOT generate an o_release pulse.
REQ-026 After reset, a key still held SHALL be re-debounced from scratch, giving the full DEBOUNCE_CYCLES+2 latency after i_reset deasserts.
REQ-027 Outputs SHALL be undefined only before the first reset edge; the bench SHALL apply reset first.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Clean press: key1 held high from edge 1 -> o_key=0001, o_press=0001 and o_code=0 appear after edge 6; o_press returns to 0 after edge 7.
REQ-029 Glitch: key2 high for 3 edges, then low -> o_key stays 0000, with no o_press or o_release pulse.
REQ-030 Bounce then settle: key3 toggles 1,0,1,0 and then holds 1 -> o_key[2] rises exactly 6 edges after the final rising sample, with a single o_press pulse.
REQ-031 Release: key1 pressed and accepted, then low -> o_key=0000, o_release=0001 and o_any=0 appear 6 edges after the first low sample.
REQ-032 Priority and simultaneity: key4 and key2 rise on the same edge -> o_press=1010 in one cycle and o_code=1; key2 is then released, after which o_code=3.
REQ-033 Reset mid-press: key1 in PRESSED, then i_reset pulsed for 1 cycle with key1 still held -> all outputs 0 and no o_release; o_key re-asserts 6 edges after reset deasserts.
